// File: rtl/noise_ctrl_pkg.sv
// noise_ctrl_pkg: shared widths, register addresses, shift divisor table and
// state encoding for the noise channel controller.
package noise_ctrl_pkg;

    localparam int unsigned ADDR_W  = 2;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned VOL_W   = 4;
    localparam int unsigned LEN_W   = 7;
    localparam int unsigned STEP_W  = 3;
    localparam int unsigned ENV_W   = 3;
    localparam int unsigned SHIFT_W = 20;

    localparam logic [ADDR_W-1:0] ADDR_NR41 = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_NR42 = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_NR43 = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_NR44 = 2'd3;

    localparam logic [LEN_W-1:0] LEN_FULL = 7'd64;

    // Shift amounts at or above this value silence the shift clock
    localparam logic [3:0] SHIFT_STOP = 4'd14;

    // Entry [r] is the base divisor for NR43[2:0] = r
    localparam logic [7:0][6:0] DIV_TABLE = {7'd112, 7'd96, 7'd80, 7'd64,
                                             7'd48,  7'd32, 7'd16, 7'd8};

    typedef enum logic {OFF, RUN} state_t;

    function automatic logic [SHIFT_W-1:0] shift_reload(input logic [DATA_W-1:0] nr43);
        logic [23:0] w_full;
        w_full = 24'(DIV_TABLE[nr43[2:0]]) << nr43[7:4];
        return SHIFT_W'(w_full - 24'd1);
    endfunction

endpackage

// File: rtl/noise_channel_ctrl_if.sv
// noise_channel_ctrl_if: register write/readback bus of the noise channel controller.
interface noise_channel_ctrl_if;
    import noise_ctrl_pkg::*;

    logic              I_WR_EN;
    logic [ADDR_W-1:0] I_ADDR;
    logic [DATA_W-1:0] I_WDATA;
    logic [DATA_W-1:0] O_RDATA;

    modport master (output I_WR_EN, output I_ADDR, output I_WDATA, input  O_RDATA);
    modport slave  (input  I_WR_EN, input  I_ADDR, input  I_WDATA, output O_RDATA);

endinterface

// File: rtl/noise_envelope.sv
// noise_envelope: volume envelope with period timer and saturating up/down step.
module noise_envelope
    import noise_ctrl_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_trigger,
    input  logic              i_env_tick,
    input  logic [DATA_W-1:0] i_nr42,
    output logic [VOL_W-1:0]  o_volume
);

    logic [VOL_W-1:0] r_volume;
    logic [ENV_W-1:0] r_timer;
    logic [ENV_W-1:0] w_period;
    logic             w_up;

    assign w_period = i_nr42[2:0];
    assign w_up     = i_nr42[3];
    assign o_volume = r_volume;

    // A timer found at 0 or 1 expires on this tick; volume never wraps
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_volume <= '0;
            r_timer  <= '0;
        end else if (i_trigger) begin
            r_volume <= i_nr42[7:4];
            r_timer  <= w_period;
        end else if (i_env_tick && (w_period != '0)) begin
            if (r_timer <= ENV_W'(1)) begin
                r_timer <= w_period;
                if (w_up && (r_volume != 4'hF)) begin
                    r_volume <= r_volume + 4'd1;
                end else if (!w_up && (r_volume != 4'h0)) begin
                    r_volume <= r_volume - 4'd1;
                end
            end else begin
                r_timer <= r_timer - ENV_W'(1);
            end
        end
    end

endmodule

// File: rtl/noise_channel_ctrl.sv
// noise_channel_ctrl: noise channel trigger, length, envelope and LFSR shift clock.
// Register readback is built only when NOISE_CTRL_READBACK_EN is defined.
module noise_channel_ctrl
    import noise_ctrl_pkg::*;
(
    input  logic                I_CLK,
    input  logic                I_RESET_N,
    input  logic                I_FRAME_TICK,
    noise_channel_ctrl_if.slave bus,
    output logic                O_SHIFT_EN,
    output logic                O_LFSR_RESET,
    output logic [VOL_W-1:0]    O_VOLUME,
    output logic                O_BIT_WIDTH,
    output logic                O_WAVEFORM_EN
);

    state_t              r_state, w_state_nxt;
    logic [DATA_W-1:0]   r_nr42, r_nr43, r_rdata;
    logic                r_len_en;
    logic [STEP_W-1:0]   r_step;
    logic [LEN_W-1:0]    r_len;
    logic [SHIFT_W-1:0]  r_shift_cnt;
    logic                r_shift_en, r_lfsr_reset, r_wave_en;

    logic w_wr_nr41, w_wr_nr42, w_wr_nr43, w_wr_nr44;
    logic w_trigger, w_dac_off_wr, w_dac_on;
    logic w_len_tick, w_env_tick, w_len_expire;
    logic [SHIFT_W-1:0] w_shift_reload;

    assign w_wr_nr41    = bus.I_WR_EN && (bus.I_ADDR == ADDR_NR41);
    assign w_wr_nr42    = bus.I_WR_EN && (bus.I_ADDR == ADDR_NR42);
    assign w_wr_nr43    = bus.I_WR_EN && (bus.I_ADDR == ADDR_NR43);
    assign w_wr_nr44    = bus.I_WR_EN && (bus.I_ADDR == ADDR_NR44);
    assign w_trigger    = w_wr_nr44 && bus.I_WDATA[7];
    assign w_dac_off_wr = w_wr_nr42 && (bus.I_WDATA[7:3] == 5'd0);
    assign w_dac_on     = (r_nr42[7:3] != 5'd0);

    // Frame ticks are decoded from the step value before it advances; trigger drops them
    assign w_len_tick   = I_FRAME_TICK && !r_step[0] && !w_trigger;
    assign w_env_tick   = I_FRAME_TICK && (r_step == 3'd7) && !w_trigger;
    assign w_len_expire = w_len_tick && !w_wr_nr41 && r_len_en && (r_len == 7'd1);

    assign w_shift_reload = shift_reload(r_nr43);

    assign O_SHIFT_EN    = r_shift_en;
    assign O_LFSR_RESET  = r_lfsr_reset;
    assign O_BIT_WIDTH   = r_nr43[3];
    assign O_WAVEFORM_EN = r_wave_en;
    assign bus.O_RDATA   = r_rdata;

    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            r_state <= OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // DAC-off has top priority, then trigger, then length expiry
    always_comb begin
        w_state_nxt = r_state;
        if (w_dac_off_wr || !w_dac_on) begin
            w_state_nxt = OFF;
        end else if (w_trigger) begin
            w_state_nxt = RUN;
        end else if (w_len_expire) begin
            w_state_nxt = OFF;
        end
    end

    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            r_nr42       <= '0;
            r_nr43       <= '0;
            r_len_en     <= 1'b0;
            r_step       <= '0;
            r_len        <= '0;
            r_lfsr_reset <= 1'b0;
            r_wave_en    <= 1'b0;
        end else begin
            if (w_wr_nr42) r_nr42   <= bus.I_WDATA;
            if (w_wr_nr43) r_nr43   <= bus.I_WDATA;
            if (w_wr_nr44) r_len_en <= bus.I_WDATA[6];
            if (I_FRAME_TICK) r_step <= r_step + 3'd1;

            if (w_wr_nr41) begin
                r_len <= LEN_FULL - {1'b0, bus.I_WDATA[5:0]};
            end else if (w_trigger) begin
                if (r_len == '0) r_len <= LEN_FULL;
            end else if (w_len_tick && r_len_en && (r_len != '0)) begin
                r_len <= r_len - 7'd1;
            end

            r_lfsr_reset <= w_trigger;
            r_wave_en    <= (w_state_nxt == RUN);
        end
    end

    // Shift timer idles at its reload value outside RUN; NR43 changes land at the next reload
    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            r_shift_cnt <= '0;
            r_shift_en  <= 1'b0;
        end else if (w_trigger || (w_state_nxt != RUN)) begin
            r_shift_cnt <= w_shift_reload;
            r_shift_en  <= 1'b0;
        end else if (r_shift_cnt == '0) begin
            r_shift_cnt <= w_shift_reload;
            r_shift_en  <= (r_nr43[7:4] < SHIFT_STOP);
        end else begin
            r_shift_cnt <= r_shift_cnt - SHIFT_W'(1);
            r_shift_en  <= 1'b0;
        end
    end

`ifdef NOISE_CTRL_READBACK_EN
    logic [DATA_W-1:0] w_rdata;

    // Unimplemented register bits read back as 1
    always_comb begin
        w_rdata = 8'hFF;
        case (bus.I_ADDR)
            ADDR_NR42: w_rdata = r_nr42;
            ADDR_NR43: w_rdata = r_nr43;
            ADDR_NR44: w_rdata = {1'b1, r_len_en, 6'h3F};
            default:   w_rdata = 8'hFF;
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) r_rdata <= '0;
        else            r_rdata <= w_rdata;
    end
`else
    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) r_rdata <= '0;
        else            r_rdata <= 8'hFF;
    end
`endif

    noise_envelope u_envelope (
        .i_clk      (I_CLK),
        .i_reset_n  (I_RESET_N),
        .i_trigger  (w_trigger),
        .i_env_tick (w_env_tick),
        .i_nr42     (r_nr42),
        .o_volume   (O_VOLUME)
    );

endmodule
